ysyx_23060124_regfile_sb: RTL and testbench

//  Parametrised multi-port integer register file with per-register pending-write scoreboard.

---
 rtl/ysyx_23060124_regfile_sb_if.sv | 31 +++
 rtl/ysyx_23060124_regfile_sb.sv | 82 ++++++++
 tb/tb_ysyx_23060124_regfile_sb.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/ysyx_23060124_regfile_sb_if.sv
// ysyx_23060124_regfile_sb_if: write, read, issue and trap-tap signals of the scoreboarded register file.
interface ysyx_23060124_regfile_sb_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2,
    parameter int NWR   = 2
);
    localparam int AW = $clog2(NREGS);
    logic [NWR-1:0]      i_wen;
    logic [NWR*AW-1:0]   i_waddr;
    logic [NWR*XLEN-1:0] i_wdata;
    logic [NRD*AW-1:0]   i_raddr;
    logic [NRD*XLEN-1:0] o_rdata;
    logic [NRD-1:0]      o_rbusy;
    logic                i_issue_vld;
    logic [AW-1:0]       i_issue_rd;
    logic                o_issue_rdy;
    logic                i_flush;
    logic [NREGS-1:0]    o_busy_vec;
    logic                i_ecall;
    logic [XLEN-1:0]     o_mret_a5;
    logic                o_a0_zero;
    modport master (
        output i_wen, i_waddr, i_wdata, i_raddr, i_issue_vld, i_issue_rd, i_flush, i_ecall,
        input  o_rdata, o_rbusy, o_issue_rdy, o_busy_vec, o_mret_a5, o_a0_zero
    );
    modport slave (
        input  i_wen, i_waddr, i_wdata, i_raddr, i_issue_vld, i_issue_rd, i_flush, i_ecall,
        output o_rdata, o_rbusy, o_issue_rdy, o_busy_vec, o_mret_a5, o_a0_zero
    );
endinterface

// File: rtl/ysyx_23060124_regfile_sb.sv
// ysyx_23060124_regfile_sb: multi-port register file with per-register pending-write counters.
// Define YSYX_RF_BYPASS_EN to forward same-cycle write data to the read ports.
module ysyx_23060124_regfile_sb #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2,
    parameter int NWR   = 2,
    parameter int PCW   = 2
) (
    input logic clk,
    input logic i_rst_n,
    ysyx_23060124_regfile_sb_if.slave bus
);
    localparam int AW   = $clog2(NREGS);
    localparam int DW   = $clog2(NWR + 1);
    localparam int CMAX = (1 << PCW) - 1;
    logic [XLEN-1:0] rf_q  [NREGS];
    logic [XLEN-1:0] rf_d  [NREGS];
    logic [PCW-1:0]  cnt_q [NREGS];
    logic [PCW-1:0]  cnt_d [NREGS];
    logic [DW-1:0]   dec_n [NREGS];
    logic            issue_go;
    // Ascending port order lets the highest enabled port win on address collisions.
    always_comb begin
        for (int r = 0; r < NREGS; r++) rf_d[r] = rf_q[r];
        for (int k = 0; k < NWR; k++)
            if (bus.i_wen[k] && bus.i_waddr[k*AW +: AW] != '0)
                rf_d[bus.i_waddr[k*AW +: AW]] = bus.i_wdata[k*XLEN +: XLEN];
    end
    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            dec_n[r] = '0;
            for (int k = 0; k < NWR; k++)
                if (bus.i_wen[k] && bus.i_waddr[k*AW +: AW] == AW'(r)) dec_n[r] = dec_n[r] + DW'(1);
        end
    end
    assign bus.o_issue_rdy = bus.i_issue_rd == '0 || cnt_q[bus.i_issue_rd] != PCW'(CMAX) ||
                             dec_n[bus.i_issue_rd] != '0;
    assign issue_go = bus.i_issue_vld && bus.o_issue_rdy && bus.i_issue_rd != '0;
    // Writes to a register with no pending issue clamp at zero rather than wrapping.
    always_comb begin
        int nxt;
        nxt = 0;
        for (int r = 0; r < NREGS; r++) begin
            nxt = int'(cnt_q[r]) + ((issue_go && bus.i_issue_rd == AW'(r)) ? 1 : 0) - int'(dec_n[r]);
            cnt_d[r] = (bus.i_flush || r == 0 || nxt <= 0) ? '0 : nxt >= CMAX ? PCW'(CMAX) : PCW'(nxt);
        end
    end
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int r = 0; r < NREGS; r++) begin
                rf_q[r]  <= '0;
                cnt_q[r] <= '0;
            end
        end else begin
            rf_q  <= rf_d;
            cnt_q <= cnt_d;
        end
    end
    always_comb begin
        bus.o_rdata = '0;
        bus.o_rbusy = '0;
        for (int k = 0; k < NRD; k++) begin
            bus.o_rdata[k*XLEN +: XLEN] = rf_q[bus.i_raddr[k*AW +: AW]];
            bus.o_rbusy[k] = cnt_q[bus.i_raddr[k*AW +: AW]] != '0;
`ifdef YSYX_RF_BYPASS_EN
            for (int w = 0; w < NWR; w++)
                if (bus.i_wen[w] && bus.i_raddr[k*AW +: AW] != '0 &&
                    bus.i_waddr[w*AW +: AW] == bus.i_raddr[k*AW +: AW]) begin
                    bus.o_rdata[k*XLEN +: XLEN] = bus.i_wdata[w*XLEN +: XLEN];
                    bus.o_rbusy[k] = 1'b0;
                end
`endif
        end
    end
    always_comb begin
        bus.o_busy_vec = '0;
        for (int r = 0; r < NREGS; r++) bus.o_busy_vec[r] = cnt_q[r] != '0;
    end
    assign bus.o_mret_a5 = bus.i_ecall ? rf_q[15] : '0;
    assign bus.o_a0_zero = rf_q[10] == '0;
endmodule

// File: tb/tb_ysyx_23060124_regfile_sb.sv
// tb_ysyx_23060124_regfile_sb: random and directed stimulus against a register-file/scoreboard model.
module tb_ysyx_23060124_regfile_sb;
    typedef struct packed {
        logic [63:0] rdata;
        logic [1:0]  rbusy;
        logic        rdy;
        logic [31:0] busy;
        logic [31:0] a5;
        logic        a0z;
    } exp_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    exp_t exp_q[$];
    exp_t e_m;
    logic [31:0] m_rf [32];
    int m_cnt [32];
    logic [4:0] pool [8] = '{5'd0, 5'd3, 5'd4, 5'd5, 5'd7, 5'd9, 5'd10, 5'd15};
    ysyx_23060124_regfile_sb_if bus ();
    ysyx_23060124_regfile_sb dut (.clk(clk), .i_rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    function automatic int hits(input logic [4:0] a);
        int n = 0;
        for (int w = 0; w < 2; w++) if (bus.i_wen[w] && bus.i_waddr[w*5 +: 5] == a) n++;
        return n;
    endfunction
    function automatic bit model_rdy();
        return bus.i_issue_rd == 0 || m_cnt[bus.i_issue_rd] != 3 || hits(bus.i_issue_rd) > 0;
    endfunction
    function automatic exp_t expect_now();
        exp_t e;
        logic [4:0] ra;
        logic [31:0] d;
        logic b;
        e = '0;
        for (int k = 0; k < 2; k++) begin
            ra = bus.i_raddr[k*5 +: 5];
            d = m_rf[ra];
            b = m_cnt[ra] != 0;
`ifdef YSYX_RF_BYPASS_EN
            for (int w = 0; w < 2; w++)
                if (bus.i_wen[w] && ra != 0 && bus.i_waddr[w*5 +: 5] == ra) begin
                    d = bus.i_wdata[w*32 +: 32];
                    b = 1'b0;
                end
`endif
            e.rdata[k*32 +: 32] = d;
            e.rbusy[k] = b;
        end
        e.rdy = model_rdy();
        for (int r = 0; r < 32; r++) e.busy[r] = m_cnt[r] != 0;
        e.a5 = bus.i_ecall ? m_rf[15] : 32'h0;
        e.a0z = m_rf[10] == 0;
        return e;
    endfunction
    function automatic void commit();
        int n;
        logic [4:0] ird;
        bit acc;
        ird = bus.i_issue_rd;
        acc = bus.i_issue_vld && model_rdy() && ird != 0;
        for (int r = 1; r < 32; r++) begin
            n = m_cnt[r] + ((acc && ird == 5'(r)) ? 1 : 0) - hits(5'(r));
            m_cnt[r] = bus.i_flush ? 0 : n < 0 ? 0 : n > 3 ? 3 : n;
        end
        for (int w = 0; w < 2; w++)
            if (bus.i_wen[w] && bus.i_waddr[w*5 +: 5] != 0) m_rf[bus.i_waddr[w*5 +: 5]] = bus.i_wdata[w*32 +: 32];
    endfunction
    task automatic drive(input logic [1:0] wen, input logic [4:0] wa0, input logic [4:0] wa1,
                         input logic [31:0] wd0, input logic [31:0] wd1, input logic [4:0] ra0,
                         input logic [4:0] ra1, input logic iv, input logic [4:0] ird,
                         input logic fl, input logic ec);
        @(posedge clk);
        #1;
        if (rst_n) commit();
        rst_n = 1'b1;
        bus.i_wen = wen;
        bus.i_waddr = {wa1, wa0};
        bus.i_wdata = {wd1, wd0};
        bus.i_raddr = {ra1, ra0};
        bus.i_issue_vld = iv;
        bus.i_issue_rd = ird;
        bus.i_flush = fl;
        bus.i_ecall = ec;
        #1 exp_q.push_back(expect_now());
    endtask
    task automatic do_reset();
        @(posedge clk);
        #1;
        if (rst_n) commit();
        rst_n = 1'b0;
        bus.i_wen = '0;
        bus.i_issue_vld = 1'b0;
        bus.i_issue_rd = 5'd6;
        bus.i_flush = 1'b0;
        bus.i_ecall = 1'b0;
        bus.i_raddr = {5'd6, 5'd5};
        for (int r = 0; r < 32; r++) begin
            m_rf[r] = '0;
            m_cnt[r] = 0;
        end
        #1 exp_q.push_back(expect_now());
    endtask
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask
    always @(negedge clk) begin
        while (exp_q.size() != 0) begin
            e_m = exp_q.pop_front();
            chk("rdata", 64'(bus.o_rdata), e_m.rdata);
            chk("rbusy", 64'(bus.o_rbusy), 64'(e_m.rbusy));
            chk("issue_rdy", 64'(bus.o_issue_rdy), 64'(e_m.rdy));
            chk("busy_vec", 64'(bus.o_busy_vec), 64'(e_m.busy));
            chk("mret_a5", 64'(bus.o_mret_a5), 64'(e_m.a5));
            chk("a0_zero", 64'(bus.o_a0_zero), 64'(e_m.a0z));
        end
    end
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end
    initial begin
        bus.i_wen = '0;
        bus.i_waddr = '0;
        bus.i_wdata = '0;
        bus.i_raddr = '0;
        bus.i_issue_vld = 1'b0;
        bus.i_issue_rd = '0;
        bus.i_flush = 1'b0;
        bus.i_ecall = 1'b0;
        do_reset();
        drive(2'b01, 5'd5, 5'd0, 32'h1234, 32'h0, 5'd5, 5'd6, 1'b1, 5'd6, 1'b0, 1'b0);
        drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd5, 5'd6, 1'b0, 5'd6, 1'b0, 1'b0);
        do_reset();
        drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd5, 5'd6, 1'b0, 5'd6, 1'b0, 1'b0);
        drive(2'b11, 5'd3, 5'd3, 32'hAAAA, 32'h5555, 5'd3, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        drive(2'b01, 5'd0, 5'd0, 32'hFFFF, 32'h0, 5'd3, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd3, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd7, 5'd0, 1'b1, 5'd7, 1'b0, 1'b0);
        drive(2'b01, 5'd7, 5'd0, 32'h77, 32'h0, 5'd7, 5'd0, 1'b0, 5'd7, 1'b0, 1'b0);
        drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd7, 5'd0, 1'b0, 5'd7, 1'b0, 1'b0);
        drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd9, 5'd0, 1'b1, 5'd9, 1'b0, 1'b0);
        drive(2'b10, 5'd0, 5'd9, 32'h0, 32'h99, 5'd9, 5'd7, 1'b1, 5'd9, 1'b0, 1'b0);
        drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd9, 5'd7, 1'b1, 5'd7, 1'b0, 1'b0);
        drive(2'b01, 5'd4, 5'd0, 32'h4444, 32'h0, 5'd9, 5'd7, 1'b0, 5'd7, 1'b1, 1'b0);
        drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd4, 5'd7, 1'b0, 5'd7, 1'b0, 1'b0);
        drive(2'b01, 5'd4, 5'd0, 32'hDEAD, 32'h0, 5'd4, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd4, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        drive(2'b10, 5'd0, 5'd15, 32'h0, 32'h42, 5'd15, 5'd10, 1'b0, 5'd0, 1'b0, 1'b0);
        drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd15, 5'd10, 1'b0, 5'd0, 1'b0, 1'b1);
        drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd15, 5'd10, 1'b0, 5'd0, 1'b0, 1'b0);
        drive(2'b01, 5'd10, 5'd0, 32'h1, 32'h0, 5'd15, 5'd10, 1'b0, 5'd0, 1'b0, 1'b1);
        drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd15, 5'd10, 1'b0, 5'd0, 1'b0, 1'b1);
        for (int i = 0; i < 400; i++) begin
            if (i == 200) do_reset();
            drive(2'($urandom_range(0, 3)), pool[$urandom_range(0, 7)], pool[$urandom_range(0, 7)],
                  $urandom, $urandom, pool[$urandom_range(0, 7)], pool[$urandom_range(0, 7)],
                  1'($urandom_range(0, 3) != 0), pool[$urandom_range(0, 7)],
                  1'($urandom_range(0, 24) == 0), 1'($urandom_range(0, 1)));
        end
        drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd10, 5'd15, 1'b0, 5'd0, 1'b0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
